cordic_scheduler: RTL and testbench

//  Shares one cordic_engine (Q2.21 angle in, Q2.21 sine/cosine out, fixed latency, no output valid) among N requesters.
//  - Arbitrates requests round-robin, at most one issue per cycle.
//  - Tracks in-flight operations with a tag delay line and captures engine outputs at the right cycle.
//  - Returns results in issue order through a credit-protected result FIFO with a valid/ready response port.

---
 rtl/cordic_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_cordic_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cordic_scheduler
// Purpose  : Shares one fixed-latency cordic_engine among N_REQ requesters.
//            Round-robin arbitration issues at most one angle per cycle.
//            A tag delay line follows each operation through the engine and
//            captures its sine/cosine on the right cycle. Results return in
//            issue order through a result FIFO. Issue is credit-limited, so
//            the FIFO can never overflow.
// Ports    : clk_i, rst_n_i        clock, synchronous active-low reset
//            req_valid_i/ready_o   per-requester handshake (ready = one-hot grant)
//            req_angle_i           packed angles, slice i = [i*W +: W]
//            rsp_valid_o/ready_i   response handshake for the FIFO head
//            rsp_id_o/sine_o/cos_o FIFO head contents
//            eng_rst_o             active-high engine reset (= ~rst_n_i)
//            eng_valid_o/angle_o   registered engine inputs
//            eng_sine_i/cos_i      engine outputs
//            busy_o                any op in flight or buffered
// Options  : CORDIC_ANGLE_WRAP_EN  range-reduce the selected angle to [-pi, pi]
// Revision : 1.0  initial release
// ============================================================================
module cordic_scheduler #(
  parameter int N_REQ       = 4,
  parameter int ENG_LATENCY = 26,
  parameter int FIFO_DEPTH  = 8,
  parameter int W           = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*W-1:0]       req_angle_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0] rsp_id_o,
  output logic [W-1:0]             rsp_sine_o,
  output logic [W-1:0]             rsp_cos_o,
  output logic                     eng_rst_o,
  output logic                     eng_valid_o,
  output logic [W-1:0]             eng_angle_o,
  input  logic [W-1:0]             eng_sine_i,
  input  logic [W-1:0]             eng_cos_i,
  output logic                     busy_o
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  // One stage per engine cycle, fed from the issue register so that the
  // tap lines up with the cycle in which the engine presents its result.
  localparam int TAGS = ENG_LATENCY + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDW-1:0]  rr_q, rr_d;
  logic            eng_valid_q, eng_valid_d;
  logic [W-1:0]    eng_angle_q, eng_angle_d;
  logic [IDW-1:0]  issue_id_q, issue_id_d;
  logic [TAGS-1:0] tag_v_q;
  logic [IDW-1:0]  tag_id_q [TAGS];
  logic [CNTW-1:0] inflight_q, inflight_d;
  logic [IDW-1:0]  mem_id_q   [FIFO_DEPTH];
  logic [W-1:0]    mem_sine_q [FIFO_DEPTH];
  logic [W-1:0]    mem_cos_q  [FIFO_DEPTH];
  logic [PTRW:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW:0]   rd_ptr_q, rd_ptr_d;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [CNTW-1:0] fifo_count;
  logic [CNTW:0]   occupancy;
  logic            credit_ok;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic [W-1:0]    sel_angle;
  logic [W-1:0]    proc_angle;
  logic            capture;
  logic            pop;

  assign eng_rst_o   = ~rst_n_i;
  assign eng_valid_o = eng_valid_q;
  assign eng_angle_o = eng_angle_q;

  // Pointers carry one extra bit, so the difference is the exact fill level.
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign occupancy   = {1'b0, inflight_q} + {1'b0, fifo_count};
  // Every op in flight already owns a FIFO slot: the engine cannot stall.
  assign credit_ok   = (occupancy < (CNTW+1)'(FIFO_DEPTH));

  assign rsp_valid_o = (wr_ptr_q != rd_ptr_q);
  assign rsp_id_o    = mem_id_q[rd_ptr_q[PTRW-1:0]];
  assign rsp_sine_o  = mem_sine_q[rd_ptr_q[PTRW-1:0]];
  assign rsp_cos_o   = mem_cos_q[rd_ptr_q[PTRW-1:0]];
  assign busy_o      = (inflight_q != '0) || rsp_valid_o;

  assign capture     = tag_v_q[TAGS-1];
  assign pop         = rsp_valid_o & rsp_ready_i;

  // --------------------------------------------------------------------------
  // Round-robin arbitration: first valid requester at or above rr_q, wrapping.
  // Held off during reset so nothing is accepted while the block is cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rst_n_i && credit_ok) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_q} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(N_REQ)) begin
          cand = cand - (IDW+1)'(N_REQ);
        end
        if (!grant_any && req_valid_i[cand[IDW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_any) begin
      req_ready_o = N_REQ'(1) << grant_idx;
    end
  end

  assign sel_angle = req_angle_i[grant_idx*W +: W];

  // --------------------------------------------------------------------------
  // Angle conditioning
  // --------------------------------------------------------------------------
`ifdef CORDIC_ANGLE_WRAP_EN
  localparam logic signed [W-1:0] PI_Q     = W'(6588397);
  localparam logic signed [W-1:0] NEG_PI_Q = -W'(6588397);
  // 2*pi does not fit as a positive W-bit value, but the wrapped result always
  // does, so modulo-2^W arithmetic yields the exact answer.
  localparam logic [W-1:0]        TWO_PI_Q = W'(13176795);

  always_comb begin
    proc_angle = sel_angle;
    if ($signed(sel_angle) > PI_Q) begin
      proc_angle = sel_angle - TWO_PI_Q;
    end else if ($signed(sel_angle) < NEG_PI_Q) begin
      proc_angle = sel_angle + TWO_PI_Q;
    end
  end
`else
  assign proc_angle = sel_angle;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rr_d        = rr_q;
    eng_valid_d = grant_any;
    eng_angle_d = eng_angle_q;
    issue_id_d  = issue_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = inflight_q;

    if (grant_any) begin
      rr_d        = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      eng_angle_d = proc_angle;
      issue_id_d  = grant_idx;
    end

    if (capture) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({grant_any, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_q        <= '0;
      eng_valid_q <= 1'b0;
      eng_angle_q <= '0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int s = 0; s < TAGS; s++) begin
        tag_id_q[s] <= '0;
      end
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_id_q[e]   <= '0;
        mem_sine_q[e] <= '0;
        mem_cos_q[e]  <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      eng_valid_q <= eng_valid_d;
      eng_angle_q <= eng_angle_d;
      issue_id_q  <= issue_id_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;

      tag_v_q     <= {tag_v_q[TAGS-2:0], eng_valid_q};
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < TAGS; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end

      if (capture) begin
        mem_id_q[wr_ptr_q[PTRW-1:0]]   <= tag_id_q[TAGS-1];
        mem_sine_q[wr_ptr_q[PTRW-1:0]] <= eng_sine_i;
        mem_cos_q[wr_ptr_q[PTRW-1:0]]  <= eng_cos_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_scheduler
// Purpose  : Self-checking bench for cordic_scheduler with a behavioural
//            fixed-latency engine and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_scheduler;

  localparam int N    = 4;
  localparam int L    = 26;
  localparam int D    = 8;
  localparam int W    = 24;
  localparam int PI_Q = 6588397;
  localparam int TOL  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_angle;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_sine;
  logic [W-1:0]     rsp_cos;
  logic             eng_rst;
  logic             eng_valid;
  logic [W-1:0]     eng_angle;
  logic [W-1:0]     eng_sine;
  logic [W-1:0]     eng_cos;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_scheduler #(.N_REQ(N), .ENG_LATENCY(L), .FIFO_DEPTH(D), .W(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_angle_i (req_angle),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sine_o  (rsp_sine),
    .rsp_cos_o   (rsp_cos),
    .eng_rst_o   (eng_rst),
    .eng_valid_o (eng_valid),
    .eng_angle_o (eng_angle),
    .eng_sine_i  (eng_sine),
    .eng_cos_i   (eng_cos),
    .busy_o      (busy)
  );

  // ---------------- behavioural engine: result L cycles after sampling ------
  logic         ev [0:L];
  logic [W-1:0] ea [0:L];

  function automatic logic [W-1:0] eng_fn(input logic [W-1:0] a, input bit c);
    real r, v;
    r = real'($signed(a)) / 2097152.0;
    v = c ? $cos(r) : $sin(r);
    return W'($rtoi(v * 2097152.0));
  endfunction

  always @(posedge clk) begin
    if (eng_rst) begin
      for (int i = 0; i <= L; i++) ev[i] <= 1'b0;
    end else begin
      ev[0] <= eng_valid;
      ea[0] <= eng_angle;
      for (int i = 1; i <= L; i++) begin
        ev[i] <= ev[i-1];
        ea[i] <= ea[i-1];
      end
    end
  end

  // Outside its valid cycle the engine shows junk, so mistimed capture shows up.
  assign eng_sine = ev[L] ? eng_fn(ea[L], 1'b0) : 24'h5A5A5A;
  assign eng_cos  = ev[L] ? eng_fn(ea[L], 1'b1) : 24'hA5A5A5;

  // ---------------- check helpers ------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_tol(input string tag, input logic [W-1:0] obs, input int exp);
    int d;
    d = int'($signed(obs)) - exp;
    checks++;
    assert ((d <= TOL && d >= -TOL) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, $signed(obs), exp, TOL);
    end
  endtask

  // Ideal trig of a Q2.21 angle, rounded to Q2.21.
  function automatic int ref_trig(input int a, input bit c);
    real r, v;
    r = real'(a) / 2097152.0;
    v = c ? $cos(r) : $sin(r);
    return $rtoi(v * 2097152.0 + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  // ---------------- reference model ----------------------------------------
  typedef struct {
    int id;
    int s;
    int c;
    int t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   m_ptr = 0;
  int   outstanding = 0;
  int   pops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int   gi;
    logic [N-1:0] exp_grant;
    exp_t e;
    if (!rst_n) begin
      chk("ready_in_reset", req_ready, 0);
      q.delete();
      m_ptr = 0;
      outstanding = 0;
    end else begin
      exp_grant = '0;
      gi = -1;
      if (outstanding < D) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        end
      end
      if (gi >= 0) exp_grant = N'(1) << gi;
      chk("grant", req_ready, exp_grant);
      chk("busy", busy, (outstanding != 0));
      chk("rsp_valid", rsp_valid, (q.size() > 0 && cyc >= q[0].t));
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk_tol("rsp_sine", rsp_sine, q[0].s);
        chk_tol("rsp_cos", rsp_cos, q[0].c);
        void'(q.pop_front());
        outstanding--;
        pops++;
      end
      if (gi >= 0) begin
        e.id = gi;
        e.s  = ref_trig(int'($signed(req_angle[gi*W +: W])), 1'b0);
        e.c  = ref_trig(int'($signed(req_angle[gi*W +: W])), 1'b1);
        // accepted at the coming edge; visible L+2 edges after that
        e.t  = cyc + 1 + L + 2;
        q.push_back(e);
        outstanding++;
        m_ptr = (gi + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_angle();
    return W'(int'($urandom_range(0, 2 * PI_Q)) - PI_Q);
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic issue_one(input int i, input logic [W-1:0] a);
    bit got;
    got = 1'b0;
    req_angle[i*W +: W] = a;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    chk("issue_timeout", got, 1'b1);
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("rsp_timeout", got, 1'b1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    int lat;
    int acc;
    int p0;
    logic [W-1:0] a5;

    rst_n     = 1'b0;
    req_valid = '1;
    req_angle = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_eng_rst", eng_rst, 1'b1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_eng_angle", eng_angle, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_sine", rsp_sine, 0);
    chk("rst_rsp_cos", rsp_cos, 0);
    chk("rst_rsp_id", rsp_id, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    chk("eng_rst_release", eng_rst, 1'b0);

    // 1: single op, latency and cos(0)
    req_angle[0 +: W] = '0;
    req_valid[0] = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    chk("t1_eng_valid", eng_valid, 1'b1);
    chk("t1_eng_angle", eng_angle, 0);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
      if (lat == 1) chk("t1_eng_valid_pulse", eng_valid, 1'b0);
    end
    chk("t1_latency", lat, L + 2);
    chk("t1_id", rsp_id, 0);
    chk_tol("t1_sine", rsp_sine, 0);
    chk_tol("t1_cos", rsp_cos, 32'h200000);
    wait_idle();

    // 2: all requesting from RR=0 -> 0,1,2,3 on consecutive cycles
    do_reset(2);
    for (int i = 0; i < N; i++) req_angle[i*W +: W] = rnd_angle();
    req_valid = '1;
    for (int g = 0; g < N; g++) begin
      #1;
      chk("t2_grant_seq", req_ready, N'(1) << g);
      tick();
      req_valid[g] = 1'b0;
    end
    wait_idle();

    // 3: consumer stalled -> exactly D accepts, then drain
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) req_angle[i*W +: W] = rnd_angle();
    req_valid = '1;
    acc = 0;
    for (int k = 0; k < 45; k++) begin
      #1;
      if (req_ready != '0) acc++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          tick();
          req_angle[i*W +: W] = rnd_angle();
          break;
        end
        if (i == N - 1) tick();
      end
    end
    #1;
    chk("t3_accepts", acc, D);
    chk("t3_no_credit", req_ready, 0);
    chk("t3_full_valid", rsp_valid, 1'b1);
    req_valid = '0;
    p0 = pops;
    rsp_ready = 1'b1;
    wait_idle();
    chk("t3_pops", pops - p0, D);

    // 4: +/- pi/2
    issue_one(1, 24'h3243F6);
    wait_rsp();
    chk_tol("t4_sine_pos", rsp_sine, 32'h200000);
    chk_tol("t4_cos_pos", rsp_cos, 0);
    wait_idle();
    issue_one(1, 24'hCDBC0A);
    wait_rsp();
    chk_tol("t4_sine_neg", rsp_sine, -32'sh200000);
    chk_tol("t4_cos_neg", rsp_cos, 0);
    wait_idle();

    // 5: out-of-range angle
    a5 = 24'h7FF7CE;
    issue_one(2, a5);
`ifdef CORDIC_ANGLE_WRAP_EN
    chk("t5_eng_angle", eng_angle, W'(-4790285));
`else
    chk("t5_eng_angle", eng_angle, a5);
`endif
    wait_rsp();
    chk_tol("t5_sine", rsp_sine, ref_trig(int'($signed(a5)), 1'b0));
    wait_idle();

    // 6: reset with ops in flight
    do_reset(2);
    for (int i = 0; i < 3; i++) req_angle[i*W +: W] = rnd_angle();
    req_valid = 4'b0111;
    for (int g = 0; g < 3; g++) begin
      tick();
      req_valid[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (10) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_busy", busy, 1'b0);
    repeat (40) tick();
    chk("t6_no_rsp", rsp_valid, 1'b0);
    issue_one(3, rnd_angle());
    wait_rsp();
    chk("t6_id", rsp_id, 3);
    wait_idle();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
